// File: rtl/odd_parity_serial_checker.sv
// Receive-side odd parity checker: deserialises an MSB-first {data, parity} codeword,
// reports the recovered data with a parity error flag and keeps a saturating error count.
module odd_parity_serial_checker #(
  parameter int input_width = 3,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   clear_count,
  output logic [input_width-1:0] data_out,
  output logic                   data_valid,
  output logic                   parity_err,
  output logic [CNT_W-1:0]       err_count,
  output logic                   busy
);

  localparam int BIT_CNT_W = $clog2(input_width + 2);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(input_width);
  localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [input_width:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   par_q, par_d;
  logic [input_width-1:0] data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic [CNT_W-1:0]       err_count_q, err_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      err_count_q  <= err_count_d;
    end
  end

  // Results are registered on the edge that accepts the last bit, so they appear in DONE.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    err_count_d  = err_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          shreg_d   = '0;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shreg_d   = {shreg_q[input_width-1:0], bit_in};
          par_d     = par_q ^ bit_in;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d      = DONE;
            data_valid_d = 1'b1;
            data_out_d   = shreg_d[input_width:1];
            parity_err_d = ~par_d;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (parity_err_q && (err_count_q != CNT_MAX))
          err_count_d = err_count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A clear always beats a same-cycle increment.
    if (clear_count)
      err_count_d = '0;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign err_count  = err_count_q;
  assign busy       = (state_q != IDLE);

endmodule
